drum_tb_sequencer: RTL and testbench

Parametrised stimulus/capture sequencer that replaces the hand-written reset/index/`$stop` logic in drum simulation benches. It drives the drum DUT's active-low reset, issues periodic strike impulses across several channels, captures DUT output samples into a readable buffer, and terminates the run by asserting `done`. It sits between the bench top level and the drum DUT. It is synthesizable, so the same sequence can also run on the board from a key press.

---
 rtl/drum_tb_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_drum_tb_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/drum_tb_sequencer.sv
// Reset/strike/capture sequencer for drum benches and board runs.
// Holds the DUT in reset, rotates strike impulses, buffers samples, flags done.
module drum_tb_sequencer #(
    parameter int WIDTH = 18,
    parameter int CHANNELS = 4,
    parameter int RESET_CYCLES = 2,
    parameter int RUN_CYCLES = 1000,
    parameter int STRIKE_PERIOD = 250,
    parameter logic signed [WIDTH-1:0] AMP = 18'sd4096,
    parameter int DEPTH = 16
) (
    input  logic                clk_50,
    input  logic                reset,
    input  logic                start,
    output logic                dut_reset,
    output logic [CHANNELS-1:0] strike,
    output logic [WIDTH-1:0]    strike_amp,
    input  logic [WIDTH-1:0]    dut_sample,
    input  logic                dut_sample_valid,
    input  logic                cap_rd_en,
    output logic [WIDTH-1:0]    cap_rd_data,
    output logic                cap_empty,
    output logic                cap_full,
    output logic                cap_overflow,
    output logic [31:0]         index,
    output logic                busy,
    output logic                done
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RST_HOLD, RUN, DONE} state_t;

    state_t state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] per_q, per_d;
    logic [31:0] index_q, index_d;
    logic [CW-1:0] ch_q, ch_d;
    logic neg_q, neg_d;
    logic [CHANNELS-1:0] strike_q, strike_d;
    logic [WIDTH-1:0] amp_q, amp_d;
    logic dut_reset_q, dut_reset_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic go;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic empty_q, empty_d;
    logic full_q, full_d;
    logic ovf_q, ovf_d;
    logic wr_req, wr_ok, rd_ok;

    assign go = start && (state_q == IDLE || state_q == DONE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        per_d    = per_q;
        index_d  = index_q;
        ch_d     = ch_q;
        neg_d    = neg_q;
        strike_d = '0;
        amp_d    = '0;
        unique case (state_q)
            IDLE, DONE: begin
                if (go) begin
                    state_d = RST_HOLD;
                    cnt_d   = '0;
                    index_d = '0;
                    ch_d    = '0;
                    neg_d   = 1'b0;
                end
            end
            RST_HOLD: begin
                index_d = index_q + 32'd1;
                if (cnt_q == 32'(RESET_CYCLES - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    per_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            RUN: begin
                index_d = index_q + 32'd1;
                cnt_d   = cnt_q + 32'd1;
                if (per_q == 32'(STRIKE_PERIOD - 1)) per_d = '0;
                else per_d = per_q + 32'd1;
                if (cnt_q == 32'(RUN_CYCLES - 1)) state_d = DONE;
            end
            default: ;
        endcase
        // Strike outputs are registered from the next-state view so the
        // first strike lands in the same cycle dut_reset releases.
        if (state_d == RUN && per_d == '0) begin
            strike_d = CHANNELS'(1) << ch_q;
            amp_d    = neg_q ? -AMP : AMP;
            if (ch_q == CW'(CHANNELS - 1)) ch_d = '0;
            else ch_d = ch_q + 1'b1;
            neg_d = ~neg_q;
        end
        dut_reset_d = (state_d == RUN) || (state_d == DONE);
        busy_d      = (state_d == RST_HOLD) || (state_d == RUN);
        done_d      = (state_d == DONE);
    end

    always_comb begin
        wr_req    = (state_q == RUN) && dut_sample_valid;
        rd_ok     = cap_rd_en && (count_q != '0);
        wr_ok     = wr_req && ((count_q != DEPTH_N) || rd_ok);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;
        ovf_d     = ovf_q;
        if (wr_ok) begin
            if (wr_ptr_q == AW'(DEPTH - 1)) wr_ptr_d = '0;
            else wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_ok) begin
            rd_data_d = mem[rd_ptr_q];
            if (rd_ptr_q == AW'(DEPTH - 1)) rd_ptr_d = '0;
            else rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_ok && !rd_ok) count_d = count_q + 1'b1;
        else if (rd_ok && !wr_ok) count_d = count_q - 1'b1;
        if (wr_req && !wr_ok) ovf_d = 1'b1;
        if (go) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end
        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_N);
    end

    always_ff @(posedge clk_50) begin
        if (wr_ok) mem[wr_ptr_q] <= dut_sample;
    end

    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            per_q       <= '0;
            index_q     <= '0;
            ch_q        <= '0;
            neg_q       <= 1'b0;
            strike_q    <= '0;
            amp_q       <= '0;
            dut_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            per_q       <= per_d;
            index_q     <= index_d;
            ch_q        <= ch_d;
            neg_q       <= neg_d;
            strike_q    <= strike_d;
            amp_q       <= amp_d;
            dut_reset_q <= dut_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            ovf_q       <= ovf_d;
        end
    end

    assign dut_reset    = dut_reset_q;
    assign strike       = strike_q;
    assign strike_amp   = amp_q;
    assign cap_rd_data  = rd_data_q;
    assign cap_empty    = empty_q;
    assign cap_full     = full_q;
    assign cap_overflow = ovf_q;
    assign index        = index_q;
    assign busy         = busy_q;
    assign done         = done_q;
endmodule

// File: tb/tb_drum_tb_sequencer.sv
// Directed bench for drum_tb_sequencer: timing vectors per sequence,
// capture/drain, overflow, full read+write, restart and reset abort.
`timescale 1ns/1ps
module tb_drum_tb_sequencer;
    localparam int W  = 18;
    localparam int CH = 4;
    localparam int NV = 12;
    localparam logic [W-1:0] AP = 18'd4096;
    localparam logic [W-1:0] AN = 18'h3F000;

    typedef struct {
        int            off;
        logic          rst;
        logic          bsy;
        logic          dn;
        logic [CH-1:0] stk;
        logic [W-1:0]  amp;
        logic [31:0]   idx;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic valid = 1'b0;
    logic rd_en = 1'b0;
    logic [W-1:0] sample = '0;
    logic dut_reset, busy, done, empty, full, ovf;
    logic [CH-1:0] strike;
    logic [W-1:0] amp, rd_data;
    logic [31:0] index;
    int n_chk = 0;
    int n_fail = 0;
    vec_t vecs [NV];

    always #10 clk = ~clk;

    drum_tb_sequencer #(
        .WIDTH(18), .CHANNELS(4), .RESET_CYCLES(2), .RUN_CYCLES(1000),
        .STRIKE_PERIOD(250), .AMP(18'sd4096), .DEPTH(16)
    ) dut (
        .clk_50(clk), .reset(rst_n), .start(start),
        .dut_reset(dut_reset), .strike(strike), .strike_amp(amp),
        .dut_sample(sample), .dut_sample_valid(valid),
        .cap_rd_en(rd_en), .cap_rd_data(rd_data),
        .cap_empty(empty), .cap_full(full), .cap_overflow(ovf),
        .index(index), .busy(busy), .done(done)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_dut_reset"}, dut_reset, 0);
        chk({tag, "_strike"}, strike, 0);
        chk({tag, "_amp"}, amp, 0);
        chk({tag, "_index"}, index, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_ovf"}, ovf, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Entered at offset 0: one edge after start was sampled.
    task automatic run_seq(input int mode);
        int vi = 0;
        int nstk = 0;
        chk("seq_start_empty", empty, 1);
        chk("seq_start_ovf", ovf, 0);
        for (int o = 0; o <= 1010; o++) begin
            if (o > 0) tick();
            if (strike != '0) nstk++;
            if (vi < NV && vecs[vi].off == o) begin
                chk($sformatf("dut_reset@%0d", o), dut_reset, vecs[vi].rst);
                chk($sformatf("busy@%0d", o), busy, vecs[vi].bsy);
                chk($sformatf("done@%0d", o), done, vecs[vi].dn);
                chk($sformatf("strike@%0d", o), strike, vecs[vi].stk);
                chk($sformatf("amp@%0d", o), amp, vecs[vi].amp);
                chk($sformatf("index@%0d", o), index, vecs[vi].idx);
                vi++;
            end
            if (mode == 2 && o == 25) chk("ovf_full_pre", full, 0);
            if (mode == 2 && o == 26) begin
                chk("ovf_full16", full, 1);
                chk("ovf_pre", ovf, 0);
            end
            if (mode == 2 && o == 27) chk("ovf_set", ovf, 1);
            if (mode == 4 && o == 31) begin
                chk("rw_data", rd_data, 1);
                chk("rw_full", full, 1);
                chk("rw_ovf", ovf, 0);
            end
            valid  = 1'b0;
            rd_en  = 1'b0;
            start  = 1'b0;
            sample = '0;
            if (mode == 1 && o >= 10 && o < 20) begin
                valid  = 1'b1;
                sample = W'(o - 9);
            end
            if (mode == 2 && o >= 10 && o < 30) begin
                valid  = 1'b1;
                sample = W'(o - 9);
            end
            if (mode == 4 && o >= 10 && o < 26) begin
                valid  = 1'b1;
                sample = W'(o - 9);
            end
            if (mode == 4 && o == 30) begin
                valid  = 1'b1;
                sample = W'(99);
                rd_en  = 1'b1;
            end
            if (mode == 3 && o == 100) start = 1'b1;
        end
        chk("strike_count", nstk, 4);
    endtask

    task automatic drain(input int n, input int first, input string tag);
        for (int i = 0; i < n; i++) begin
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            tick();
            chk($sformatf("%s_rd%0d", tag, i), rd_data, first + i);
        end
    endtask

    initial begin
        vecs[0]  = '{0,    1'b0, 1'b1, 1'b0, 4'b0000, '0, 32'd0};
        vecs[1]  = '{1,    1'b0, 1'b1, 1'b0, 4'b0000, '0, 32'd1};
        vecs[2]  = '{2,    1'b1, 1'b1, 1'b0, 4'b0001, AP, 32'd2};
        vecs[3]  = '{3,    1'b1, 1'b1, 1'b0, 4'b0000, '0, 32'd3};
        vecs[4]  = '{251,  1'b1, 1'b1, 1'b0, 4'b0000, '0, 32'd251};
        vecs[5]  = '{252,  1'b1, 1'b1, 1'b0, 4'b0010, AN, 32'd252};
        vecs[6]  = '{253,  1'b1, 1'b1, 1'b0, 4'b0000, '0, 32'd253};
        vecs[7]  = '{502,  1'b1, 1'b1, 1'b0, 4'b0100, AP, 32'd502};
        vecs[8]  = '{752,  1'b1, 1'b1, 1'b0, 4'b1000, AN, 32'd752};
        vecs[9]  = '{1001, 1'b1, 1'b1, 1'b0, 4'b0000, '0, 32'd1001};
        vecs[10] = '{1002, 1'b1, 1'b0, 1'b1, 4'b0000, '0, 32'd1002};
        vecs[11] = '{1010, 1'b1, 1'b0, 1'b1, 4'b0000, '0, 32'd1002};

        repeat (3) tick();
        reset_vals("por");
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_busy", busy, 0);
        chk("idle_dut_reset", dut_reset, 0);

        go();
        run_seq(3);

        go();
        run_seq(1);
        drain(10, 1, "cap");
        chk("cap_empty", empty, 1);
        chk("cap_ovf", ovf, 0);

        go();
        run_seq(2);
        chk("ovf_sticky", ovf, 1);
        drain(16, 1, "ovf");
        chk("ovf_empty", empty, 1);

        go();
        run_seq(4);
        drain(15, 2, "rw");
        drain(1, 99, "rw_last");
        chk("rw_empty", empty, 1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
        chk("empty_rd_hold", rd_data, 99);
        chk("empty_rd_empty", empty, 1);

        go();
        run_seq(1);
        drain(3, 1, "part");
        chk("part_nonempty", empty, 0);
        go();
        run_seq(0);

        go();
        valid  = 1'b1;
        sample = W'(7);
        for (int i = 0; i < 100 && index != 32'd40; i++) tick();
        chk("abort_index", index, 40);
        chk("abort_nonempty", empty, 0);
        #2;
        rst_n = 1'b0;
        #1;
        reset_vals("abort");
        valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        reset_vals("post");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
